led_blink_array: RTL and testbench
==================================

# led_blink_array

Parametrised multi-channel LED driver for board-level status indication. It generalises the fixed two-LED, fixed-rate blinker to CH_NUM channels, each with a runtime-programmable half-period and mode (OFF / ON / BLINK / ONESHOT). A shared prescaler produces a millisecond-class time base, so per-channel counters stay narrow. A software or top-level FSM drives it through a single-cycle configuration write port.

## Interface
- CH_NUM, 2: number of LED channels (1..16)
- CH_W, 1: width of cfg_ch; must satisfy 2^CH_W >= CH_NUM
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz
- TICK_HZ, 1000: time-base tick rate; TICK_DIV = CLK_FREQ/TICK_HZ (integer, >= 2)
- PER_W, 16: half-period counter width, in ticks
- DEF_HALF, 500: reset half-period of channel 0; channel i resets to max(DEF_HALF >> i, 1)
- INIT_LED, 2'b01: CH_NUM-bit reset/restart level of each LED
- sys_clk  in  1  system clock, single clock domain
- sys_rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  one-cycle configuration write strobe
- cfg_ch  in  CH_W  target channel; values >= CH_NUM are ignored
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
- cfg_half  in  PER_W  half-period / one-shot length in ticks; 0 is treated as 1
- sync_rst  in  1  synchronous phase restart of all channels
- tick  out  1  one-cycle time-base pulse
- led  out  CH_NUM  LED drive, active high

## Operation
- Prescaler: pre_cnt counts 0..TICK_DIV-1 and wraps. tick = 1 for exactly the cycle in which pre_cnt == TICK_DIV-1.
- Per-channel state: mode (2 b), half (PER_W), cnt (PER_W), lvl (1 b).
- Reset state: pre_cnt = 0; tick = 0; every mode = BLINK; half per DEF_HALF rule; cnt = 0; led = INIT_LED.
- OFF: lvl = 0, cnt held at 0.
- ON: lvl = 1, cnt held at 0.
- BLINK: on each tick, if cnt == half-1 then cnt <= 0 and lvl toggles; otherwise cnt++. Half-period = half*TICK_DIV cycles.
- ONESHOT: lvl = 1. On each tick cnt++. When cnt == half-1 on a tick, lvl <= 0 and mode <= OFF (autonomous transition).
- Write (cfg_we = 1, cfg_ch < CH_NUM): the next cycle loads mode, half = max(cfg_half, 1) and cnt = 0. lvl <= 1 for ON, BLINK and ONESHOT; lvl <= 0 for OFF. Other channels are untouched.
- sync_rst: the next cycle sets pre_cnt = 0, every cnt = 0, and lvl = INIT_LED bit for BLINK channels. ONESHOT channels restart their full length. Modes and halves are kept.
- sync_rst and cfg_we in the same cycle: sync_rst applies to all channels; the write then overrides the addressed channel.
- Write coinciding with a tick: the write wins for that channel, so that tick is not counted.
- Counters never exceed half-1. Wrap is exact, with no drift across periods.
- Asynchronous reset mid-operation: all state returns to the reset values immediately, regardless of pending ONESHOT or writes.

## Timing
- led is registered. A write in cycle N is visible on led in cycle N+1.
- In BLINK after a write at N, the first toggle occurs on the half-th tick after N+1. The phase relative to the free-running prescaler is not reset by a write; only sync_rst aligns it.
- tick latency: the first tick arrives TICK_DIV cycles after reset release.
- No backpressure: writes are accepted every cycle, back-to-back.

## Configuration
- LED_PWM_DIM_EN defined: adds input dim [3:0] and a free-running 4-bit pwm_cnt (reset 0). Output becomes led[i] = lvl[i] & (pwm_cnt <= dim), still registered, giving a duty of (dim+1)/16. dim = 15 means full on. Brightness applies to all channels.
- LED_PWM_DIM_EN undefined: the dim port and pwm_cnt are absent, and led = lvl directly.

## Test plan
Bench parameters: CLK_FREQ = 100, TICK_HZ = 10 (TICK_DIV = 10), DEF_HALF = 4, CH_NUM = 2.

- Reset release, no writes -> tick every 10 cycles. led[0] starts at 1 and toggles every 40 cycles. led[1] starts at 0 and toggles every 20 cycles.
- Write ch1 ONESHOT, half = 3 -> led[1] = 1 the next cycle, falls to 0 on the 3rd subsequent tick, then stays 0 (mode reads as OFF).
- Write ch0 BLINK, half = 0 -> led[0] toggles on every tick (period 20 cycles).
- Write with cfg_ch = 3 -> no LED change; all counters continue undisturbed.
- sync_rst and a ch0 ON write in the same cycle -> next cycle led = 2'b01. ch1 counter restarts; its next toggle is 2 ticks after pre_cnt restarts at 0.
- With LED_PWM_DIM_EN, dim = 3, ch0 ON -> led[0] high 4 of every 16 cycles. With dim = 15 -> constantly high.
- Assert sys_rst_n low mid-ONESHOT -> led = 2'b01 immediately; after release, the default blink resumes.

Source files
------------

// File: rtl/led_blink_array.sv
// led_blink_array: CH_NUM-channel LED driver with a shared tick prescaler and per-channel
// OFF/ON/BLINK/ONESHOT modes. Define LED_PWM_DIM_EN to add global PWM dimming via 'dim'.
module led_blink_array #(
  parameter int unsigned       CH_NUM   = 2,
  parameter int unsigned       CH_W     = 1,
  parameter int unsigned       CLK_FREQ = 50_000_000,
  parameter int unsigned       TICK_HZ  = 1000,
  parameter int unsigned       PER_W    = 16,
  parameter int unsigned       DEF_HALF = 500,
  parameter logic [CH_NUM-1:0] INIT_LED = 2'b01
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_half,
  input  logic              sync_rst,
`ifdef LED_PWM_DIM_EN
  input  logic [3:0]        dim,
`endif
  output logic              tick,
  output logic [CH_NUM-1:0] led
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PRE_W    = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  // Channel i resets to DEF_HALF >> i, clamped so no channel starts with a zero half-period.
  function automatic logic [PER_W-1:0] f_def_half(input int unsigned ch);
    int unsigned h;
    h = DEF_HALF >> ch;
    return (h == 0) ? PER_W'(1) : PER_W'(h);
  endfunction

  logic [PRE_W-1:0]  r_pre_cnt;
  logic [PRE_W-1:0]  w_pre_nxt;
  mode_e             r_mode     [CH_NUM];
  mode_e             w_mode_nxt [CH_NUM];
  logic [PER_W-1:0]  r_half     [CH_NUM];
  logic [PER_W-1:0]  w_half_nxt [CH_NUM];
  logic [PER_W-1:0]  r_cnt      [CH_NUM];
  logic [PER_W-1:0]  w_cnt_nxt  [CH_NUM];
  logic [CH_NUM-1:0] r_lvl;
  logic [CH_NUM-1:0] w_lvl_nxt;
  logic [CH_NUM-1:0] w_wr_hit;
  logic [CH_NUM-1:0] w_at_end;
  logic              w_tick;
  logic [PER_W-1:0]  w_cfg_half;
  mode_e             w_cfg_mode;

  assign w_tick     = (r_pre_cnt == PRE_W'(TICK_DIV - 1));
  assign tick       = w_tick;
  assign w_cfg_half = (cfg_half == '0) ? PER_W'(1) : cfg_half;
  assign w_cfg_mode = mode_e'(cfg_mode);
  assign w_pre_nxt  = (sync_rst || w_tick) ? '0 : r_pre_cnt + PRE_W'(1);

  always_comb begin
    w_wr_hit = '0;
    w_at_end = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      w_wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
      w_at_end[i] = (r_cnt[i] == r_half[i] - PER_W'(1));
    end
  end

  // Priority per channel: addressed write, then sync_rst, then normal tick-driven mode behaviour.
  always_comb begin
    w_lvl_nxt = r_lvl;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      w_mode_nxt[i] = r_mode[i];
      w_half_nxt[i] = r_half[i];
      w_cnt_nxt[i]  = r_cnt[i];
      if (w_wr_hit[i]) begin
        w_mode_nxt[i] = w_cfg_mode;
        w_half_nxt[i] = w_cfg_half;
        w_cnt_nxt[i]  = '0;
        w_lvl_nxt[i]  = (w_cfg_mode != MODE_OFF);
      end else if (sync_rst) begin
        w_cnt_nxt[i] = '0;
        if (r_mode[i] == MODE_BLINK) begin
          w_lvl_nxt[i] = INIT_LED[i];
        end
      end else begin
        case (r_mode[i])
          MODE_OFF: begin
            w_cnt_nxt[i] = '0;
            w_lvl_nxt[i] = 1'b0;
          end
          MODE_ON: begin
            w_cnt_nxt[i] = '0;
            w_lvl_nxt[i] = 1'b1;
          end
          MODE_BLINK: begin
            if (w_tick) begin
              if (w_at_end[i]) begin
                w_cnt_nxt[i] = '0;
                w_lvl_nxt[i] = ~r_lvl[i];
              end else begin
                w_cnt_nxt[i] = r_cnt[i] + PER_W'(1);
              end
            end
          end
          MODE_ONESHOT: begin
            w_lvl_nxt[i] = 1'b1;
            if (w_tick) begin
              if (w_at_end[i]) begin
                w_cnt_nxt[i]  = '0;
                w_lvl_nxt[i]  = 1'b0;
                w_mode_nxt[i] = MODE_OFF;
              end else begin
                w_cnt_nxt[i] = r_cnt[i] + PER_W'(1);
              end
            end
          end
          default: begin
            w_cnt_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pre_cnt <= '0;
      r_lvl     <= INIT_LED;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        r_mode[i] <= MODE_BLINK;
        r_half[i] <= f_def_half(i);
        r_cnt[i]  <= '0;
      end
    end else begin
      r_pre_cnt <= w_pre_nxt;
      r_lvl     <= w_lvl_nxt;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        r_mode[i] <= w_mode_nxt[i];
        r_half[i] <= w_half_nxt[i];
        r_cnt[i]  <= w_cnt_nxt[i];
      end
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [3:0]        r_pwm_cnt;
  logic [3:0]        w_pwm_nxt;
  logic [CH_NUM-1:0] r_led;

  assign w_pwm_nxt = r_pwm_cnt + 4'd1;

  // Gate with next-cycle values so led stays aligned with lvl (write at N visible at N+1).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pwm_cnt <= '0;
      r_led     <= INIT_LED;
    end else begin
      r_pwm_cnt <= w_pwm_nxt;
      r_led     <= w_lvl_nxt & {CH_NUM{w_pwm_nxt <= dim}};
    end
  end

  assign led = r_led;
`else
  assign led = r_lvl;
`endif

endmodule

// File: tb/tb_led_blink_array.sv
// Scoreboard bench for led_blink_array: a tick-count reference model predicts {tick, led}
// each cycle; a negedge monitor pops and compares.
module tb_led_blink_array;

  localparam int TDIV      = 10;
  localparam int CHN       = 2;
  localparam int M_OFF     = 0;
  localparam int M_ON      = 1;
  localparam int M_BLINK   = 2;
  localparam int M_ONESHOT = 3;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_we    = 1'b0;
  logic [1:0]  cfg_ch    = '0;
  logic [1:0]  cfg_mode  = '0;
  logic [15:0] cfg_half  = '0;
  logic        sync_rst  = 1'b0;
  logic        tick;
  logic [1:0]  led;
`ifdef LED_PWM_DIM_EN
  logic [3:0]  dim       = 4'hf;
`endif

  led_blink_array #(
    .CH_NUM   (2),
    .CH_W     (2),
    .CLK_FREQ (100),
    .TICK_HZ  (10),
    .PER_W    (16),
    .DEF_HALF (4),
    .INIT_LED (2'b01)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .sync_rst  (sync_rst),
`ifdef LED_PWM_DIM_EN
    .dim       (dim),
`endif
    .tick      (tick),
    .led       (led)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         mon_cyc  = 0;
  bit         mon_en   = 1'b0;
  logic [2:0] exp_q [$];
  logic [2:0] mon_exp;
  logic [1:0] init_v   = 2'b01;

  // Reference model: prescaler phase plus, per channel, ticks counted since the last (re)start.
  int m_phase;
  int m_mode  [CHN];
  int m_half  [CHN];
  int m_ticks [CHN];
  bit m_base  [CHN];

  function automatic bit m_lvl(input int c);
    case (m_mode[c])
      M_ON:      return 1'b1;
      M_ONESHOT: return 1'b1;
      M_BLINK:   return m_base[c] ^ (((m_ticks[c] / m_half[c]) % 2) != 0);
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] m_out();
    return {(m_phase == TDIV - 1), m_lvl(1), m_lvl(0)};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    for (int c = 0; c < CHN; c++) begin
      m_mode[c]  = M_BLINK;
      m_half[c]  = ((4 >> c) == 0) ? 1 : (4 >> c);
      m_ticks[c] = 0;
      m_base[c]  = init_v[c];
    end
  endtask

  task automatic model_step(input bit we, input int ch, input int mode, input int half, input bit srst);
    bit t;
    t = (m_phase == TDIV - 1);
    m_phase = srst ? 0 : (m_phase + 1) % TDIV;
    for (int c = 0; c < CHN; c++) begin
      if (we && ch == c) begin
        m_mode[c]  = mode;
        m_half[c]  = (half == 0) ? 1 : half;
        m_ticks[c] = 0;
        m_base[c]  = 1'b1;
      end else if (srst) begin
        m_ticks[c] = 0;
        if (m_mode[c] == M_BLINK) m_base[c] = init_v[c];
      end else if (t && (m_mode[c] == M_BLINK || m_mode[c] == M_ONESHOT)) begin
        m_ticks[c]++;
        if (m_mode[c] == M_ONESHOT && m_ticks[c] >= m_half[c]) begin
          m_mode[c]  = M_OFF;
          m_ticks[c] = 0;
        end
      end
    end
  endtask

  // Entered at 1 time unit after a posedge; applies inputs for this cycle and queues the
  // output expected after the coming edge.
  task automatic drive(input bit we, input int ch, input int mode, input int half, input bit srst);
    cfg_we   = we;
    cfg_ch   = 2'(ch);
    cfg_mode = 2'(mode);
    cfg_half = 16'(half);
    sync_rst = srst;
    model_step(we, ch, mode, half, srst);
    exp_q.push_back(m_out());
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      mon_cyc++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_underflow cyc=%0d got tick=%b led=%b required a queued entry",
                 mon_cyc, tick, led);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({tick, led} !== mon_exp) begin
          n_errors++;
          $display("FAIL led_tick cyc=%0d got tick=%b led=%b required tick=%b led=%b",
                   mon_cyc, tick, led, mon_exp[2], mon_exp[1:0]);
        end
      end
    end
  end

  task automatic release_reset();
    sys_rst_n = 1'b1;
    model_reset();
    exp_q.push_back(m_out());
    mon_en = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("reset_led", 32'(led), 32'h1);
    chk("reset_tick", 32'(tick), 32'h0);
    repeat (2) @(posedge sys_clk);
    #1;
    release_reset();

    idle(100);
    drive(1'b1, 1, M_ONESHOT, 3, 1'b0);
    idle(60);
    drive(1'b1, 0, M_BLINK, 0, 1'b0);
    idle(50);
    drive(1'b1, 3, int'($urandom_range(3)), int'($urandom_range(9)), 1'b0);
    idle(30);
    drive(1'b1, 0, M_ON, 5, 1'b1);
    idle(40);

    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(7) == 0, int'($urandom_range(3)), int'($urandom_range(3)),
            int'($urandom_range(6)), $urandom_range(39) == 0);
    end

    drive(1'b1, 1, M_ONESHOT, 50, 1'b0);
    idle(20);
    mon_en = 1'b0;
    exp_q.delete();
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_reset_led", 32'(led), 32'h1);
    chk("async_reset_tick", 32'(tick), 32'h0);
    repeat (2) @(posedge sys_clk);
    #1;
    chk("held_reset_led", 32'(led), 32'h1);
    release_reset();
    idle(100);

    @(negedge sys_clk);
    #1;
    mon_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
